// File: rtl/uart_frame_cfg.sv
//==============================================================================
// Module      : uart_frame_cfg
// Description : Parameterised UART (data width, parity, stop bits) with a 16x
//               oversampled, majority-voting receiver.
//               Optional macro UART_BREAK_DETECT_EN adds the rxBreak output.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_frame_cfg #(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxEn,
    input  logic                 rxIn,
    output logic                 rxBusy,
    output logic                 rxDone,
    output logic                 rxErr,
    output logic                 rxParityErr,
    output logic [DATA_BITS-1:0] rxOut,
`ifdef UART_BREAK_DETECT_EN
    output logic                 rxBreak,
`endif
    input  logic                 txEn,
    input  logic                 txStart,
    input  logic [DATA_BITS-1:0] txIn,
    output logic                 txBusy,
    output logic                 txDone,
    output logic                 txOut
);

    localparam int DIV      = (CLOCK_RATE + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
    localparam int BIT_CLKS = DIV * OVERSAMPLE;
    localparam int DIV_W    = $clog2(DIV + 1);
    localparam int BIT_W    = $clog2(BIT_CLKS + 1);
    localparam int OS_W     = $clog2(OVERSAMPLE + 1);
    localparam int IDX_W    = 4;

    localparam logic [DIV_W-1:0] c_div_last  = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] c_bit_last  = BIT_W'(BIT_CLKS - 1);
    localparam logic [BIT_W-1:0] c_bit_prev  = BIT_W'(BIT_CLKS - 2);
    localparam logic [OS_W-1:0]  c_os_last   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  c_smp_a     = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  c_smp_b     = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  c_smp_c     = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [IDX_W-1:0] c_data_last = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] c_stop_last = IDX_W'(STOP_BITS - 1);
    localparam logic             c_has_par   = (PARITY != 0);
    localparam logic             c_odd       = (PARITY == 2);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    // Shared oversampling tick
    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;

    assign w_tick = (r_div_cnt == c_div_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      r_div_cnt <= '0;
        else if (w_tick) r_div_cnt <= '0;
        else             r_div_cnt <= r_div_cnt + 1'b1;
    end

    // Transmitter: its bit timer restarts at acceptance so every bit is exact
    tx_state_t            r_tx_state;
    logic [BIT_W-1:0]     r_tx_cnt;
    logic [IDX_W-1:0]     r_tx_idx;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_tx_out;
    logic                 r_tx_busy;
    logic                 r_tx_done;
    logic                 w_tx_accept;
    logic                 w_tx_last_stop;

    assign w_tx_accept    = txEn && txStart;
    assign w_tx_last_stop = (r_tx_state == TX_STOP) && (r_tx_idx == c_stop_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_out   <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= w_tx_last_stop && (r_tx_cnt == c_bit_prev);
            if (r_tx_state == TX_IDLE) begin
                if (w_tx_accept) begin
                    r_tx_state <= TX_START;
                    r_tx_shift <= txIn;
                    r_tx_par   <= (^txIn) ^ c_odd;
                    r_tx_cnt   <= '0;
                    r_tx_idx   <= '0;
                    r_tx_out   <= 1'b0;
                    r_tx_busy  <= 1'b1;
                end
            end else if (r_tx_cnt != c_bit_last) begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end else begin
                r_tx_cnt <= '0;
                case (r_tx_state)
                    TX_START: begin
                        r_tx_state <= TX_DATA;
                        r_tx_out   <= r_tx_shift[0];
                    end
                    TX_DATA: begin
                        if (r_tx_idx == c_data_last) begin
                            r_tx_idx <= '0;
                            if (c_has_par) begin
                                r_tx_state <= TX_PARITY;
                                r_tx_out   <= r_tx_par;
                            end else begin
                                r_tx_state <= TX_STOP;
                                r_tx_out   <= 1'b1;
                            end
                        end else begin
                            r_tx_idx   <= r_tx_idx + 1'b1;
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_out   <= r_tx_shift[1];
                        end
                    end
                    TX_PARITY: begin
                        r_tx_state <= TX_STOP;
                        r_tx_out   <= 1'b1;
                    end
                    TX_STOP: begin
                        if (!w_tx_last_stop) begin
                            r_tx_idx <= r_tx_idx + 1'b1;
                        end else if (w_tx_accept) begin
                            // Back-to-back frame with no idle gap
                            r_tx_state <= TX_START;
                            r_tx_shift <= txIn;
                            r_tx_par   <= (^txIn) ^ c_odd;
                            r_tx_idx   <= '0;
                            r_tx_out   <= 1'b0;
                        end else begin
                            r_tx_state <= TX_IDLE;
                            r_tx_out   <= 1'b1;
                            r_tx_busy  <= 1'b0;
                        end
                    end
                    default: r_tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    assign txOut  = r_tx_out;
    assign txBusy = r_tx_busy;
    assign txDone = r_tx_done;

    // Receiver input synchroniser plus one extra stage for edge detection
    logic r_rx_s1, r_rx_s2, r_rx_s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= rxIn;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    rx_state_t            r_rx_state;
    logic [OS_W-1:0]      r_rx_tick;
    logic [IDX_W-1:0]     r_rx_idx;
    logic [1:0]           r_rx_smp;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_ferr;
    logic                 r_rx_perr_pend;
    logic                 r_rx_busy;
    logic                 r_rx_done;
    logic                 r_rx_err;
    logic                 r_rx_perr;
    logic [DATA_BITS-1:0] r_rx_out;
    logic                 w_rx_fall;
    logic                 w_vote;
    logic                 w_vote_now;

    assign w_rx_fall  = r_rx_s3 && !r_rx_s2;
    assign w_vote     = (r_rx_smp[0] & r_rx_smp[1]) | (r_rx_smp[0] & r_rx_s2) | (r_rx_smp[1] & r_rx_s2);
    assign w_vote_now = w_tick && (r_rx_tick == c_smp_c);

`ifdef UART_BREAK_DETECT_EN
    logic r_rx_allzero;
    logic r_rx_break;

    // Cleared by any high vote; the start bit can only vote low here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        r_rx_allzero <= 1'b0;
        else if (r_rx_state == RX_IDLE)    r_rx_allzero <= 1'b1;
        else if (w_vote_now && w_vote)     r_rx_allzero <= 1'b0;
    end

    assign rxBreak = r_rx_break;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state     <= RX_IDLE;
            r_rx_tick      <= '0;
            r_rx_idx       <= '0;
            r_rx_smp       <= '0;
            r_rx_shift     <= '0;
            r_rx_ferr      <= 1'b0;
            r_rx_perr_pend <= 1'b0;
            r_rx_busy      <= 1'b0;
            r_rx_done      <= 1'b0;
            r_rx_err       <= 1'b0;
            r_rx_perr      <= 1'b0;
            r_rx_out       <= '0;
`ifdef UART_BREAK_DETECT_EN
            r_rx_break     <= 1'b0;
`endif
        end else begin
            r_rx_done <= 1'b0;
`ifdef UART_BREAK_DETECT_EN
            r_rx_break <= 1'b0;
`endif
            if (!rxEn) begin
                r_rx_state <= RX_IDLE;
                r_rx_busy  <= 1'b0;
            end else begin
                case (r_rx_state)
                    RX_IDLE: begin
                        if (w_rx_fall) begin
                            r_rx_state     <= RX_START;
                            r_rx_busy      <= 1'b1;
                            r_rx_tick      <= '0;
                            r_rx_idx       <= '0;
                            r_rx_ferr      <= 1'b0;
                            r_rx_perr_pend <= 1'b0;
                        end
                    end
                    RX_WAIT_HIGH: begin
                        if (r_rx_s2) r_rx_state <= RX_IDLE;
                    end
                    default: begin
                        if (w_tick) begin
                            r_rx_tick <= (r_rx_tick == c_os_last) ? '0 : r_rx_tick + 1'b1;
                            if (r_rx_tick == c_smp_a) r_rx_smp[0] <= r_rx_s2;
                            if (r_rx_tick == c_smp_b) r_rx_smp[1] <= r_rx_s2;
                        end
                        if (w_vote_now) begin
                            case (r_rx_state)
                                RX_START: begin
                                    if (w_vote) begin
                                        r_rx_state <= RX_IDLE;
                                        r_rx_busy  <= 1'b0;
                                    end else begin
                                        r_rx_state <= RX_DATA;
                                    end
                                end
                                RX_DATA: begin
                                    r_rx_shift <= {w_vote, r_rx_shift[DATA_BITS-1:1]};
                                    if (r_rx_idx == c_data_last) begin
                                        r_rx_idx   <= '0;
                                        r_rx_state <= c_has_par ? RX_PARITY : RX_STOP;
                                    end else begin
                                        r_rx_idx <= r_rx_idx + 1'b1;
                                    end
                                end
                                RX_PARITY: begin
                                    r_rx_perr_pend <= w_vote ^ (^r_rx_shift) ^ c_odd;
                                    r_rx_state     <= RX_STOP;
                                end
                                RX_STOP: begin
                                    if (r_rx_idx != c_stop_last) begin
                                        r_rx_idx <= r_rx_idx + 1'b1;
                                        if (!w_vote) r_rx_ferr <= 1'b1;
                                    end else begin
                                        r_rx_busy <= 1'b0;
`ifdef UART_BREAK_DETECT_EN
                                        if (r_rx_allzero && !w_vote) begin
                                            r_rx_break <= 1'b1;
                                            r_rx_state <= RX_WAIT_HIGH;
                                        end else
`endif
                                        begin
                                            r_rx_done  <= 1'b1;
                                            r_rx_out   <= r_rx_shift;
                                            r_rx_err   <= r_rx_ferr | !w_vote;
                                            r_rx_perr  <= c_has_par & r_rx_perr_pend;
                                            // A low stop bit must see the line high again before re-arming
                                            r_rx_state <= (r_rx_ferr | !w_vote) ? RX_WAIT_HIGH : RX_IDLE;
                                        end
                                    end
                                end
                                default: r_rx_state <= RX_IDLE;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    assign rxBusy      = r_rx_busy;
    assign rxDone      = r_rx_done;
    assign rxErr       = r_rx_err;
    assign rxParityErr = r_rx_perr;
    assign rxOut       = r_rx_out;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_cfg.sv
//==============================================================================
// Module      : tb_uart_frame_cfg
// Description : Directed bench for uart_frame_cfg: 8N1 default instance and a
//               fast 7E1 instance driven bit by bit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_frame_cfg;

    localparam int BIT0 = 1248;
    localparam int BIT1 = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: defaults, optional loopback
    logic       loop0 = 1'b0;
    logic       rxd_in0 = 1'b1;
    logic       rxEn0 = 1'b1, txEn0 = 1'b1, txStart0 = 1'b0;
    logic [7:0] txIn0 = 8'h00;
    logic       rxBusy0, rxDone0, rxErr0, rxPerr0, txBusy0, txDone0, txOut0;
    logic [7:0] rxOut0;
    logic       w_rx0;
    assign w_rx0 = loop0 ? txOut0 : rxd_in0;

    // Instance 1: 7E1 at 128 clocks per bit
    logic       rx1 = 1'b1;
    logic       rxBusy1, rxDone1, rxErr1, rxPerr1, txBusy1, txDone1, txOut1;
    logic [6:0] rxOut1;
`ifdef UART_BREAK_DETECT_EN
    logic       brk0, brk1;
    int         brk1_cnt = 0;
`endif

    uart_frame_cfg u0 (
        .clk(clk), .reset(rst_n), .rxEn(rxEn0), .rxIn(w_rx0),
        .rxBusy(rxBusy0), .rxDone(rxDone0), .rxErr(rxErr0), .rxParityErr(rxPerr0), .rxOut(rxOut0),
`ifdef UART_BREAK_DETECT_EN
        .rxBreak(brk0),
`endif
        .txEn(txEn0), .txStart(txStart0), .txIn(txIn0),
        .txBusy(txBusy0), .txDone(txDone0), .txOut(txOut0)
    );

    uart_frame_cfg #(
        .CLOCK_RATE(1200000), .BAUD_RATE(9600), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16)
    ) u1 (
        .clk(clk), .reset(rst_n), .rxEn(1'b1), .rxIn(rx1),
        .rxBusy(rxBusy1), .rxDone(rxDone1), .rxErr(rxErr1), .rxParityErr(rxPerr1), .rxOut(rxOut1),
`ifdef UART_BREAK_DETECT_EN
        .rxBreak(brk1),
`endif
        .txEn(1'b0), .txStart(1'b0), .txIn(7'h00),
        .txBusy(txBusy1), .txDone(txDone1), .txOut(txOut1)
    );

    // Event monitors
    int         rxd0 = 0, txd0 = 0, br0 = 0, rxd1 = 0, br1 = 0;
    logic       bq0 = 1'b0, bq1 = 1'b0;
    logic [7:0] rx0_log [16];

    always @(negedge clk) begin
        if (rxDone0) begin
            rx0_log[rxd0 % 16] <= rxOut0;
            rxd0 <= rxd0 + 1;
        end
        if (txDone0) txd0 <= txd0 + 1;
        if (rxDone1) rxd1 <= rxd1 + 1;
        bq0 <= rxBusy0;
        bq1 <= rxBusy1;
        if (rxBusy0 && !bq0) br0 <= br0 + 1;
        if (rxBusy1 && !bq1) br1 <= br1 + 1;
`ifdef UART_BREAK_DETECT_EN
        if (brk1) brk1_cnt <= brk1_cnt + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_k(input int target);
        int guard = 0;
        while (cyc < target && guard < 200000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic check_tx_bits(input string tag, input logic [7:0] d, input int t0, input int first);
        logic [9:0] f;
        f = {1'b1, d, 1'b0};
        for (int b = first; b < 10; b++) begin
            wait_k(t0 + b * BIT0 + BIT0 / 2);
            check(tag, 32'(txOut0), 32'(f[b]));
        end
    endtask

    task automatic drive_u1(input logic [15:0] frame, input int nbits, input logic fin);
        for (int i = 0; i < nbits; i++) begin
            rx1 = frame[i];
            repeat (BIT1) @(negedge clk);
        end
        rx1 = fin;
    endtask

    int t0, n_tx, n_rx, n_br;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txOut",  32'(txOut0),  32'd1);
        check("rst_txBusy", 32'(txBusy0), 32'd0);
        check("rst_txDone", 32'(txDone0), 32'd0);
        check("rst_rxBusy", 32'(rxBusy0), 32'd0);
        check("rst_rxDone", 32'(rxDone0), 32'd0);
        check("rst_rxErr",  32'(rxErr0),  32'd0);
        check("rst_rxPerr", 32'(rxPerr0), 32'd0);
        check("rst_rxOut",  32'(rxOut0),  32'd0);
        check("rst_u1_tx",  32'({txOut1, txBusy1, txDone1}), 32'b100);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Loopback single frame 0x7A
        loop0 = 1'b1; txIn0 = 8'h7A; txStart0 = 1'b1;
        @(negedge clk);
        t0 = cyc; txStart0 = 1'b0; n_tx = txd0; n_rx = rxd0;
        check("t1_busy", 32'(txBusy0), 32'd1);
        check("t1_startlow", 32'(txOut0), 32'd0);
        wait_k(t0 + 1247);         check("t1_start_end", 32'(txOut0), 32'd0);
        wait_k(t0 + 2495);         check("t1_d0_end",    32'(txOut0), 32'd0);
        wait_k(t0 + 2496);         check("t1_d1_begin",  32'(txOut0), 32'd1);
        check_tx_bits("t1_bit", 8'h7A, t0, 2);
        wait_k(t0 + 12478);        check("t1_done_early", 32'(txDone0), 32'd0);
        wait_k(t0 + 12479);        check("t1_done",       32'(txDone0), 32'd1);
        wait_k(t0 + 12480);
        check("t1_done_off", 32'(txDone0), 32'd0);
        check("t1_busy_off", 32'(txBusy0), 32'd0);
        check("t1_txd_cnt",  32'(txd0 - n_tx), 32'd1);
        check("t1_rxd_cnt",  32'(rxd0 - n_rx), 32'd1);
        check("t1_rxOut",    32'(rxOut0), 32'h7A);
        check("t1_rxErr",    32'(rxErr0), 32'd0);
        check("t1_rxPerr",   32'(rxPerr0), 32'd0);

        // Held txStart: two frames, zero gap, txIn changed mid-frame
        txIn0 = 8'h7A; txStart0 = 1'b1;
        @(negedge clk);
        t0 = cyc; n_tx = txd0; n_rx = rxd0;
        wait_k(t0 + 11856); txIn0 = 8'hB1;
        wait_k(t0 + 12479); check("t2_stop_high", 32'(txOut0), 32'd1);
        wait_k(t0 + 12480);
        check("t2_nogap_low",  32'(txOut0), 32'd0);
        check("t2_nogap_busy", 32'(txBusy0), 32'd1);
        txStart0 = 1'b0;
        wait_k(t0 + 24960);
        check("t2_busy_off", 32'(txBusy0), 32'd0);
        check("t2_txd_cnt",  32'(txd0 - n_tx), 32'd2);
        check("t2_rxd_cnt",  32'(rxd0 - n_rx), 32'd2);
        check("t2_rx_first", 32'(rx0_log[n_rx % 16]), 32'h7A);
        check("t2_rx_second", 32'(rx0_log[(n_rx + 1) % 16]), 32'hB1);

        // Short glitch is a false start
        repeat (10) @(negedge clk);
        loop0 = 1'b0; rxd_in0 = 1'b1;
        repeat (10) @(negedge clk);
        n_br = br0; n_rx = rxd0;
        rxd_in0 = 1'b0;
        repeat (300) @(negedge clk);
        rxd_in0 = 1'b1;
        repeat (2 * BIT0) @(negedge clk);
        check("t3_busy_pulse", 32'(br0 - n_br), 32'd1);
        check("t3_busy_off",   32'(rxBusy0), 32'd0);
        check("t3_no_done",    32'(rxd0 - n_rx), 32'd0);
        check("t3_rxOut_hold", 32'(rxOut0), 32'hB1);

        // Reset mid-transmission
        txIn0 = 8'h3C; txStart0 = 1'b1;
        @(negedge clk);
        t0 = cyc; txStart0 = 1'b0; n_tx = txd0;
        wait_k(t0 + 4 * BIT0 + 600);
        rst_n = 1'b0;
        #1;
        check("t4_rst_txOut",  32'(txOut0),  32'd1);
        check("t4_rst_txBusy", 32'(txBusy0), 32'd0);
        @(negedge clk);
        check("t4_rst_rxOut", 32'(rxOut0), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT0) @(negedge clk);
        check("t4_no_done", 32'(txd0 - n_tx), 32'd0);
        loop0 = 1'b1; txIn0 = 8'hA5; txStart0 = 1'b1;
        @(negedge clk);
        t0 = cyc; txStart0 = 1'b0; n_tx = txd0; n_rx = rxd0;
        check_tx_bits("t4_bit", 8'hA5, t0, 0);
        wait_k(t0 + 12481);
        check("t4_txd_cnt", 32'(txd0 - n_tx), 32'd1);
        check("t4_rxd_cnt", 32'(rxd0 - n_rx), 32'd1);
        check("t4_rxOut",   32'(rxOut0), 32'hA5);
        check("t4_rxErr",   32'(rxErr0), 32'd0);

        // 7E1: wrong parity, correct parity, another byte
        repeat (64) @(negedge clk);
        n_rx = rxd1;
        drive_u1({6'd0, 1'b1, 1'b1, 7'h55, 1'b0}, 10, 1'b1);
        check("p_bad_done", 32'(rxd1 - n_rx), 32'd1);
        check("p_bad_out",  32'(rxOut1), 32'h55);
        check("p_bad_perr", 32'(rxPerr1), 32'd1);
        check("p_bad_ferr", 32'(rxErr1), 32'd0);
        repeat (64) @(negedge clk);
        n_rx = rxd1;
        drive_u1({6'd0, 1'b1, 1'b0, 7'h55, 1'b0}, 10, 1'b1);
        check("p_ok_done", 32'(rxd1 - n_rx), 32'd1);
        check("p_ok_out",  32'(rxOut1), 32'h55);
        check("p_ok_perr", 32'(rxPerr1), 32'd0);
        repeat (64) @(negedge clk);
        drive_u1({6'd0, 1'b1, 1'b1, 7'h0E, 1'b0}, 10, 1'b1);
        check("p_0e_out",  32'(rxOut1), 32'h0E);
        check("p_0e_perr", 32'(rxPerr1), 32'd0);

        // Framing error followed by a long low line
        repeat (64) @(negedge clk);
        n_rx = rxd1; n_br = br1;
        drive_u1({3'd0, 3'b000, 1'b0, 1'b0, 7'h55, 1'b0}, 13, 1'b0);
        check("f_done",     32'(rxd1 - n_rx), 32'd1);
        check("f_err",      32'(rxErr1), 32'd1);
        check("f_out",      32'(rxOut1), 32'h55);
        check("f_busy_one", 32'(br1 - n_br), 32'd1);
        check("f_busy_low", 32'(rxBusy1), 32'd0);
        rx1 = 1'b1;
        repeat (3 * BIT1) @(negedge clk);
        check("f_no_phantom", 32'(br1 - n_br), 32'd1);
        check("f_done_once",  32'(rxd1 - n_rx), 32'd1);

        // All-zero frame
        n_rx = rxd1;
        drive_u1(16'd0, 10, 1'b1);
`ifdef UART_BREAK_DETECT_EN
        check("brk_pulse",  32'(brk1_cnt), 32'd1);
        check("brk_nodone", 32'(rxd1 - n_rx), 32'd0);
        check("brk_hold",   32'(rxOut1), 32'h55);
`else
        check("brk_done", 32'(rxd1 - n_rx), 32'd1);
        check("brk_out",  32'(rxOut1), 32'h00);
        check("brk_err",  32'(rxErr1), 32'd1);
`endif
        repeat (BIT1) @(negedge clk);
        n_rx = rxd1;
        drive_u1({6'd0, 1'b1, 1'b1, 7'h0E, 1'b0}, 10, 1'b1);
        check("rec_done", 32'(rxd1 - n_rx), 32'd1);
        check("rec_out",  32'(rxOut1), 32'h0E);
        check("rec_err",  32'(rxErr1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
